// File: rtl/verin_ctrl_pkg.sv
// Shared constants for the cylinder stroke controller.
// Holds the FSM state encoding, the Avalon register word addresses and the
// bit positions inside the CTRL, STATUS and IRQ registers.
package verin_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_EXTEND    = 3'd1;
  localparam logic [2:0] ST_EXTENDED  = 3'd2;
  localparam logic [2:0] ST_RETRACT   = 3'd3;
  localparam logic [2:0] ST_RETRACTED = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
  localparam logic [1:0] ADDR_IRQ     = 2'd3;

  localparam int CTRL_EXTEND    = 0;
  localparam int CTRL_RETRACT   = 1;
  localparam int CTRL_STOP      = 2;
  localparam int CTRL_CLR_FAULT = 3;

  localparam int STAT_FAULT = 5;
  localparam int STAT_PEND  = 6;
  localparam int STAT_BOTH  = 7;

  localparam int IRQ_EN   = 0;
  localparam int IRQ_PEND = 1;

  function automatic logic is_moving(input logic [2:0] st);
    return (st == ST_EXTEND) || (st == ST_RETRACT);
  endfunction

endpackage

// File: rtl/verin_limit_filter.sv
// Limit-switch conditioning: SYNC_STAGES-deep synchroniser per bit, followed
// (when LIMIT_DEBOUNCE_EN is defined) by a per-bit debounce counter that only
// lets the filtered value follow the synchroniser after DEB_CYCLES consecutive
// samples that disagree with the current filtered value.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_raw  [W-1:0] asynchronous sensor inputs
//   o_filt [W-1:0] synchronised (and optionally debounced) sensor values
// Configuration macro: LIMIT_DEBOUNCE_EN
module verin_limit_filter #(
  parameter int W           = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_filt
);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_param_chk
    $error("verin_limit_filter: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0]                  w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef LIMIT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [W-1:0][CNT_W-1:0] r_cnt;
  logic [W-1:0]            r_filt;

  // Counter tracks how long the synced bit has disagreed with the filtered
  // value; any agreeing sample restarts the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (w_sync[b] == r_filt[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_W'(DEB_CYCLES - 1)) begin
          r_filt[b] <= w_sync[b];
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign o_filt = r_filt;
`else
  assign o_filt = w_sync;
`endif

endmodule

// File: rtl/verin_stroke_ctrl.sv
// Avalon-MM slave sequencing one double-acting cylinder: drives the extend and
// retract valves, watches the two end-of-stroke switches, times out strokes,
// latches faults and raises a level interrupt on stroke completion or fault.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[1:0]        register word select (CTRL/STATUS/TIMEOUT/IRQ)
//   chipselect, write_n write qualifier (write_n active-low)
//   writedata[31:0]     write data
//   readdata[31:0]      registered read data, 1-cycle latency
//   limit_in[1:0]       async sensors, [0]=retracted end, [1]=extended end
//   out_extend          extend valve drive
//   out_retract         retract valve drive
//   irq                 irq_pending & irq_en
// Configuration macro: LIMIT_DEBOUNCE_EN (enables sensor debounce).
module verin_stroke_ctrl
  import verin_ctrl_pkg::*;
#(
  parameter int TO_W        = 24,
  parameter int TIMEOUT_RST = 5_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  limit_in,
  output logic        out_extend,
  output logic        out_retract,
  output logic        irq
);

  logic [1:0]      w_lim;
  logic            w_wr;
  logic            w_ctrl_wr;
  logic            w_unused_wd;
  logic            r_cmd_ext, r_cmd_ret, r_cmd_stop, r_cmd_clr;
  logic [TO_W-1:0] r_timeout;
  logic [TO_W-1:0] r_cnt;
  logic            r_irq_en, r_pending, r_both_err;
  logic [2:0]      r_state, w_next;
  logic            w_both, w_to_hit;
  logic            w_ext_d, w_ret_d, w_irq_set;
  logic [31:0]     w_status;

  verin_limit_filter #(
    .W          (2),
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_limit_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .i_raw  (limit_in),
    .o_filt (w_lim)
  );

  assign w_wr = chipselect & ~write_n;
  // A CTRL write asking for both directions at once is discarded entirely.
  assign w_ctrl_wr = w_wr && (address == ADDR_CTRL) &&
                     !(writedata[CTRL_EXTEND] && writedata[CTRL_RETRACT]);
  // Data bits above the implemented register fields are don't-care.
  assign w_unused_wd = ^writedata;

  // CTRL bits are one-cycle strobes consumed by the FSM on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ext  <= 1'b0;
      r_cmd_ret  <= 1'b0;
      r_cmd_stop <= 1'b0;
      r_cmd_clr  <= 1'b0;
    end else begin
      r_cmd_ext  <= w_ctrl_wr && writedata[CTRL_EXTEND];
      r_cmd_ret  <= w_ctrl_wr && writedata[CTRL_RETRACT];
      r_cmd_stop <= w_ctrl_wr && writedata[CTRL_STOP];
      r_cmd_clr  <= w_ctrl_wr && writedata[CTRL_CLR_FAULT];
    end
  end

  assign w_both   = &w_lim;
  assign w_to_hit = (r_timeout != '0) && (r_cnt == r_timeout - TO_W'(1));

  // FSM state register plus registered valve outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      out_extend  <= 1'b0;
      out_retract <= 1'b0;
    end else begin
      r_state     <= w_next;
      out_extend  <= w_ext_d;
      out_retract <= w_ret_d;
    end
  end

  // Next state. Both-sensor error outranks STOP; sensor arrival outranks timeout.
  always_comb begin
    w_next = r_state;
    if (r_state == ST_FAULT) begin
      if (r_cmd_clr) w_next = ST_IDLE;
    end else if (w_both && r_state != ST_IDLE) begin
      w_next = ST_FAULT;
    end else if (r_cmd_stop) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_EXTENDED, ST_RETRACTED: begin
          if (r_cmd_ext)      w_next = ST_EXTEND;
          else if (r_cmd_ret) w_next = ST_RETRACT;
        end
        ST_EXTEND: begin
          if (w_lim[1])      w_next = ST_EXTENDED;
          else if (w_to_hit) w_next = ST_FAULT;
        end
        ST_RETRACT: begin
          if (w_lim[0])      w_next = ST_RETRACTED;
          else if (w_to_hit) w_next = ST_FAULT;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so valves track the state register.
  always_comb begin
    w_ext_d   = (w_next == ST_EXTEND);
    w_ret_d   = (w_next == ST_RETRACT);
    w_irq_set = (w_next != r_state) &&
                ((w_next == ST_EXTENDED) || (w_next == ST_RETRACTED) ||
                 (w_next == ST_FAULT));
  end

  // Stroke counter restarts on every state change and saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (is_moving(r_state) && !(&r_cnt)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout  <= TO_W'(TIMEOUT_RST);
      r_irq_en   <= 1'b0;
      r_pending  <= 1'b0;
      r_both_err <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_TIMEOUT) r_timeout <= writedata[TO_W-1:0];
      if (w_wr && address == ADDR_IRQ)     r_irq_en  <= writedata[IRQ_EN];
      if (w_irq_set)
        r_pending <= 1'b1;
      else if (w_wr && address == ADDR_IRQ && writedata[IRQ_PEND])
        r_pending <= 1'b0;
      if (r_state == ST_FAULT && r_cmd_clr)
        r_both_err <= 1'b0;
      else if (w_both && r_state != ST_FAULT)
        r_both_err <= 1'b1;
    end
  end

  assign irq = r_pending & r_irq_en;

  always_comb begin
    w_status             = '0;
    w_status[2:0]        = r_state;
    w_status[4:3]        = w_lim;
    w_status[STAT_FAULT] = (r_state == ST_FAULT);
    w_status[STAT_PEND]  = r_pending;
    w_status[STAT_BOTH]  = r_both_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_STATUS:  readdata <= w_status;
        ADDR_TIMEOUT: readdata <= 32'(r_timeout);
        ADDR_IRQ:     readdata <= {30'b0, r_pending, r_irq_en};
        default:      readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_verin_stroke_ctrl.sv
module tb_verin_stroke_ctrl;

  localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_TIMEOUT = 2'd2, A_IRQ = 2'd3;
  localparam int SYNC = 2;
`ifdef LIMIT_DEBOUNCE_EN
  localparam int LAT = SYNC + 8 + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  limit_in;
  logic        out_extend;
  logic        out_retract;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  verin_stroke_ctrl #(
    .TO_W       (24),
    .TIMEOUT_RST(5_000_000),
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .limit_in   (limit_in),
    .out_extend (out_extend),
    .out_retract(out_retract),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; limit_in = 2'b00;
    cyc(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_ext", {31'b0, out_extend}, 32'h0);
    chk("rst_ret", {31'b0, out_retract}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    chk_rd("rst_status", A_STATUS, 32'h0);
    chk_rd("rst_timeout", A_TIMEOUT, 32'd5_000_000);
    chk_rd("rst_irqreg", A_IRQ, 32'h0);

    // T1: extend, sensor arrival, completion without irq enable
    wr(A_TIMEOUT, 100);
    wr(A_CTRL, 32'h1);
    chk("t1_ext_write_cycle", {31'b0, out_extend}, 32'h0);
    cyc(1);
    chk("t1_ext_on", {31'b0, out_extend}, 32'h1);
    chk_rd("t1_status_moving", A_STATUS, 32'h01);
    cyc(15);
    limit_in = 2'b10;
    cyc(LAT - 1);
    chk("t1_ext_before_arrival", {31'b0, out_extend}, 32'h1);
    cyc(1);
    chk("t1_ext_off", {31'b0, out_extend}, 32'h0);
    chk("t1_irq_masked", {31'b0, irq}, 32'h0);
    chk_rd("t1_status_extended", A_STATUS, 32'h52);

    // T2: retract timeout into FAULT with irq enabled
    limit_in = 2'b00;
    cyc(LAT + 1);
    wr(A_IRQ, 32'h3);
    cyc(1);
    chk("t2_irq_cleared", {31'b0, irq}, 32'h0);
    wr(A_TIMEOUT, 50);
    wr(A_CTRL, 32'h2);
    cyc(50);
    chk("t2_ret_before_to", {31'b0, out_retract}, 32'h1);
    chk("t2_irq_before_to", {31'b0, irq}, 32'h0);
    cyc(1);
    chk("t2_ret_fault", {31'b0, out_retract}, 32'h0);
    chk("t2_ext_fault", {31'b0, out_extend}, 32'h0);
    chk("t2_irq_fault", {31'b0, irq}, 32'h1);
    chk_rd("t2_status_fault", A_STATUS, 32'h65);
    wr(A_CTRL, 32'h2);
    cyc(1);
    chk("t2_cmd_in_fault", {31'b0, out_retract}, 32'h0);
    chk_rd("t2_status_sticky", A_STATUS, 32'h65);
    wr(A_CTRL, 32'h8);
    cyc(1);
    chk_rd("t2_status_clr", A_STATUS, 32'h40);
    wr(A_IRQ, 32'h3);
    cyc(1);
    chk("t2_irq_ack", {31'b0, irq}, 32'h0);

    // T3: arrival on the timeout terminal cycle wins
    wr(A_TIMEOUT, 20);
    wr(A_CTRL, 32'h1);
    cyc(21 - LAT);
    limit_in = 2'b10;
    cyc(LAT - 1);
    chk("t3_ext_before_term", {31'b0, out_extend}, 32'h1);
    cyc(1);
    chk("t3_ext_off", {31'b0, out_extend}, 32'h0);
    chk_rd("t3_status_arrival_wins", A_STATUS, 32'h52);

    // T3: TIMEOUT=0 disables the timeout
    limit_in = 2'b00;
    cyc(LAT + 1);
    wr(A_TIMEOUT, 0);
    wr(A_CTRL, 32'h1);
    cyc(10000);
    chk("t3_no_timeout_ext", {31'b0, out_extend}, 32'h1);
    chk_rd("t3_no_timeout_status", A_STATUS, 32'h41);

    // T5: STOP mid-stroke
    wr(A_CTRL, 32'h4);
    chk("t5_stop_write_cycle", {31'b0, out_extend}, 32'h1);
    cyc(1);
    chk("t5_stop_ext", {31'b0, out_extend}, 32'h0);
    chk_rd("t5_stop_status", A_STATUS, 32'h40);

    // T4: both sensors during EXTEND -> FAULT with STATUS[7]
    wr(A_TIMEOUT, 1000);
    wr(A_CTRL, 32'h1);
    cyc(2);
    chk("t4_ext_on", {31'b0, out_extend}, 32'h1);
    limit_in = 2'b11;
    cyc(LAT - 1);
    chk("t4_ext_before_both", {31'b0, out_extend}, 32'h1);
    cyc(1);
    chk("t4_ext_fault", {31'b0, out_extend}, 32'h0);
    chk_rd("t4_status_both", A_STATUS, 32'hFD);
    limit_in = 2'b00;
    cyc(LAT + 1);
    wr(A_CTRL, 32'h8);
    cyc(1);
    chk_rd("t4_status_clr", A_STATUS, 32'h40);
    wr(A_CTRL, 32'h3);
    cyc(2);
    chk("t4_dual_ext", {31'b0, out_extend}, 32'h0);
    chk("t4_dual_ret", {31'b0, out_retract}, 32'h0);
    chk_rd("t4_dual_status", A_STATUS, 32'h40);
    wr(A_CTRL, 32'h5);
    cyc(2);
    chk("t4_stop_prio_ext", {31'b0, out_extend}, 32'h0);
    limit_in = 2'b11;
    cyc(LAT + 1);
    chk_rd("t4_idle_both", A_STATUS, 32'hD8);
    limit_in = 2'b00;
    cyc(LAT + 1);

    // T5: async reset mid-stroke
    wr(A_CTRL, 32'h2);
    cyc(1);
    chk("t5_ret_on", {31'b0, out_retract}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_rst_ret", {31'b0, out_retract}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_rd("t5_timeout_rst", A_TIMEOUT, 32'd5_000_000);
    chk_rd("t5_status_rst", A_STATUS, 32'h0);
    chk_rd("t5_irqreg_rst", A_IRQ, 32'h0);

`ifdef LIMIT_DEBOUNCE_EN
    // T6: 7-cycle glitch is filtered, 8 stable cycles pass
    wr(A_TIMEOUT, 1000);
    wr(A_CTRL, 32'h1);
    cyc(1);
    limit_in = 2'b10;
    cyc(7);
    limit_in = 2'b00;
    cyc(15);
    chk("t6_glitch_ignored", {31'b0, out_extend}, 32'h1);
    limit_in = 2'b10;
    cyc(LAT - 1);
    chk("t6_before_stable", {31'b0, out_extend}, 32'h1);
    cyc(1);
    chk("t6_stable_arrival", {31'b0, out_extend}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
